// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters.
// It latches the operands, holds them for a per-opcode time, then holds the result until the owner accepts it.
module alu_arbiter #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned OTHER_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [5:0]  r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [7:0]  r0_flags,
    output logic        r0_resp_valid,
    input  logic        r0_resp_ready,
    output logic [31:0] r0_result,
    output logic [7:0]  r0_flags_out,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [5:0]  r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [7:0]  r1_flags,
    output logic        r1_resp_valid,
    input  logic        r1_resp_ready,
    output logic [31:0] r1_result,
    output logic [7:0]  r1_flags_out,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_op,
    output logic [7:0]  alu_flags_in,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_flags_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        ptr;    // requester granted most recently
    logic        owner;
    logic [31:0] a_q, b_q;
    logic [5:0]  op_q;
    logic [7:0]  flags_q;
    logic [31:0] result_q [2];
    logic [7:0]  flags_out_q [2];

    logic        grant_valid, grant_id;
    logic [5:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic [7:0]  sel_flags;
    logic [3:0]  hold_cycles;

    always_comb begin
        grant_id = 1'b0;
        if (r0_valid && r1_valid) grant_id = ~ptr;
        else if (r1_valid)        grant_id = 1'b1;
        grant_valid = (state == IDLE) && rst_n && (r0_valid || r1_valid);
    end

    assign r0_ready  = grant_valid && !grant_id;
    assign r1_ready  = grant_valid && grant_id;
    assign sel_op    = grant_id ? r1_op    : r0_op;
    assign sel_a     = grant_id ? r1_a     : r0_a;
    assign sel_b     = grant_id ? r1_b     : r0_b;
    assign sel_flags = grant_id ? r1_flags : r0_flags;

    // MUL, DIV and MOD are the multi-cycle paths through the ALU.
    assign hold_cycles = (sel_op >= 6'h08 && sel_op <= 6'h0A) ? 4'(MULDIV_CYCLES) : 4'(OTHER_CYCLES);

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = EXEC;
            EXEC:    if (cnt == 4'd1) state_next = RESP;
            RESP:    if (owner ? r1_resp_ready : r0_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking (<=) throughout, so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= 1'b1;
            owner          <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            flags_q        <= '0;
            // NOTE: the response registers are cleared too, because the result outputs must read 0 after reset.
            result_q[0]    <= '0;
            result_q[1]    <= '0;
            flags_out_q[0] <= '0;
            flags_out_q[1] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        flags_q <= sel_flags;
                        owner   <= grant_id;
                        ptr     <= grant_id;
                        cnt     <= hold_cycles;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        result_q[owner]    <= alu_result;
                        flags_out_q[owner] <= alu_flags_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;
    assign alu_flags_in  = flags_q;
    assign r0_resp_valid = (state == RESP) && !owner;
    assign r1_resp_valid = (state == RESP) && owner;
    assign r0_result     = result_q[0];
    assign r1_result     = result_q[1];
    assign r0_flags_out  = flags_out_q[0];
    assign r1_flags_out  = flags_out_q[1];
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a behavioural ALU stand-in and a transaction-timing reference model.
// Directed scenarios run first, then randomized two-requester traffic.
module tb_alu_arbiter;

    localparam int MD = 4;
    localparam int OT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r0_resp_valid, r0_resp_ready;
    logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready;
    logic [5:0]  r0_op, r1_op, alu_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b;
    logic [7:0]  r0_flags, r1_flags, alu_flags_in;
    logic [31:0] r0_result, r1_result, alu_result;
    logic [7:0]  r0_flags_out, r1_flags_out, alu_flags_out;
    logic        busy;

    always #5 clk = ~clk;

    alu_arbiter #(.MULDIV_CYCLES(MD), .OTHER_CYCLES(OT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_flags(r0_flags), .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r0_result(r0_result), .r0_flags_out(r0_flags_out),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_flags(r1_flags), .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .r1_result(r1_result), .r1_flags_out(r1_flags_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_flags_out(alu_flags_out), .busy(busy)
    );

    // ALU stand-in: returns {flags, result}; bit1 of flags is the zero flag.
    function automatic logic [39:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [7:0] fi);
        logic [32:0] w;
        logic [31:0] r;
        logic [7:0]  f;
        w = '0; r = '0; f = '0;
        case (op)
            6'h00: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; f[0] = w[32]; end
            6'h01: begin r = a - b; f[0] = (a < b); end
            6'h02: r = a & b;
            6'h03: r = a | b;
            6'h04: r = a ^ b;
            6'h05: r = a << b[4:0];
            6'h06: r = a >> b[4:0];
            6'h07: r = $signed(a) >>> b[4:0];
            6'h08: r = a * b;
            6'h09: if (b == 0) begin r = '1; f = 8'h05; end else r = a / b;
            6'h0A: if (b == 0) begin r = a;  f = 8'h05; end else r = a % b;
            6'h0B: r = a + b + {31'b0, fi[0]};
            6'h0C: r = b;
            default: r = '0;
        endcase
        if (r == 0) f[1] = 1'b1;
        return {f, r};
    endfunction

    always_comb {alu_flags_out, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_flags_in);

    function automatic int hold(input logic [5:0] op);
        return (op >= 6'h08 && op <= 6'h0A) ? MD : OT;
    endfunction

    int n_checks, n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester-side stimulus state, applied to the pins once per cycle.
    bit          rst_s, auto_drop;
    bit          v_s [2];
    bit          rr_s [2];
    logic [5:0]  op_s [2];
    logic [31:0] a_s [2], b_s [2];
    logic [7:0]  f_s [2];

    // What the bench saw in the most recent cycle.
    bit          o_ready [2], o_rv [2], o_busy;
    logic [31:0] o_res [2], o_alu_a;
    logic [7:0]  o_flo [2];
    int          grants [$];

    // Reference model: one outstanding transaction, described by its owner and its response time.
    int          m_pend, m_resp_at, m_ptr, cyc;
    logic [39:0] m_exp;
    logic [31:0] m_res [2], m_a, m_b;
    logic [7:0]  m_flo [2], m_f;
    logic [5:0]  m_op;

    task automatic model_reset();
        m_pend = -1; m_ptr = 1; m_resp_at = 0;
        m_res[0] = '0; m_res[1] = '0; m_flo[0] = '0; m_flo[1] = '0;
        m_a = '0; m_b = '0; m_op = '0; m_f = '0; m_exp = '0;
    endtask

    task automatic set_req(input int n, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [7:0] f);
        v_s[n] = 1'b1; op_s[n] = op; a_s[n] = a; b_s[n] = b; f_s[n] = f;
    endtask

    task automatic tick();
        int g;
        @(posedge clk); #2;
        rst_n = rst_s;
        r0_valid = v_s[0]; r0_op = op_s[0]; r0_a = a_s[0]; r0_b = b_s[0]; r0_flags = f_s[0];
        r1_valid = v_s[1]; r1_op = op_s[1]; r1_a = a_s[1]; r1_b = b_s[1]; r1_flags = f_s[1];
        r0_resp_ready = rr_s[0]; r1_resp_ready = rr_s[1];
        #2;
        g = -1;
        if (rst_s && m_pend < 0) begin
            if (v_s[0] && v_s[1]) g = 1 - m_ptr;
            else if (v_s[0])      g = 0;
            else if (v_s[1])      g = 1;
        end
        check("r0_ready",      64'(r0_ready),      64'(g == 0));
        check("r1_ready",      64'(r1_ready),      64'(g == 1));
        check("busy",          64'(busy),          64'(m_pend >= 0));
        check("r0_resp_valid", 64'(r0_resp_valid), 64'(m_pend == 0 && cyc >= m_resp_at));
        check("r1_resp_valid", 64'(r1_resp_valid), 64'(m_pend == 1 && cyc >= m_resp_at));
        check("r0_result",     64'(r0_result),     64'(m_res[0]));
        check("r1_result",     64'(r1_result),     64'(m_res[1]));
        check("r0_flags_out",  64'(r0_flags_out),  64'(m_flo[0]));
        check("r1_flags_out",  64'(r1_flags_out),  64'(m_flo[1]));
        check("alu_a",         64'(alu_a),         64'(m_a));
        check("alu_b",         64'(alu_b),         64'(m_b));
        check("alu_op",        64'(alu_op),        64'(m_op));
        check("alu_flags_in",  64'(alu_flags_in),  64'(m_f));
        o_ready[0] = r0_ready; o_ready[1] = r1_ready; o_rv[0] = r0_resp_valid; o_rv[1] = r1_resp_valid;
        o_res[0] = r0_result; o_res[1] = r1_result; o_flo[0] = r0_flags_out; o_flo[1] = r1_flags_out;
        o_busy = busy; o_alu_a = alu_a;
        if (r0_ready === 1'b1) grants.push_back(0);
        if (r1_ready === 1'b1) grants.push_back(1);
        if (!rst_s) model_reset();
        else if (g >= 0) begin
            m_pend = g; m_ptr = g; m_resp_at = cyc + hold(op_s[g]) + 1;
            m_op = op_s[g]; m_a = a_s[g]; m_b = b_s[g]; m_f = f_s[g];
            m_exp = alu_fn(m_op, m_a, m_b, m_f);
            if (auto_drop) v_s[g] = 1'b0;
        end else if (m_pend >= 0 && cyc + 1 == m_resp_at) begin
            m_res[m_pend] = m_exp[31:0]; m_flo[m_pend] = m_exp[39:32];
        end else if (m_pend >= 0 && cyc >= m_resp_at && rr_s[m_pend]) begin
            m_pend = -1;
        end
        cyc++;
    endtask

    task automatic wait_grant(input int n, input string tag);
        int k;
        k = 0;
        do begin tick(); k++; end while (!o_ready[n] && k < 40);
        check(tag, 64'(o_ready[n]), 64'd1);
    endtask

    // Returns the number of cycles from the grant cycle to the first response-valid cycle.
    task automatic wait_resp(input int n, output int lat);
        lat = 0;
        while (!o_rv[n] && lat < 40) begin tick(); lat++; end
    endtask

    task automatic drain();
        int k;
        k = 0;
        v_s[0] = 1'b0; v_s[1] = 1'b0; rr_s[0] = 1'b1; rr_s[1] = 1'b1;
        do begin tick(); k++; end while (o_busy && k < 40);
        check("drain_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_checks = 0; n_fail = 0; cyc = 0; auto_drop = 1'b1;
        rst_s = 1'b0; rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            v_s[n] = 1'b0; rr_s[n] = 1'b0; op_s[n] = '0; a_s[n] = '0; b_s[n] = '0; f_s[n] = '0;
        end
        r0_valid = 0; r0_op = '0; r0_a = '0; r0_b = '0; r0_flags = '0; r0_resp_ready = 0;
        r1_valid = 0; r1_op = '0; r1_a = '0; r1_b = '0; r1_flags = '0; r1_resp_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        rst_s = 1'b1;
        tick();

        // Single ADD from r0.
        set_req(0, 6'h00, 32'd5, 32'd7, 8'h00); rr_s[0] = 1'b1;
        wait_grant(0, "add_grant");
        wait_resp(0, lat);
        check("add_latency", 64'(lat), 64'(OT + 1));
        check("add_result",  64'(o_res[0]), 64'd12);
        check("add_flags",   64'(o_flo[0]), 64'h00);
        check("add_busy",    64'(o_busy),   64'd1);
        drain();

        // Both requesters continuously valid: strict alternation starting at r0.
        rst_s = 1'b0; tick(); rst_s = 1'b1;
        grants.delete();
        auto_drop = 1'b0;
        set_req(0, 6'h01, 32'd50, 32'd8, 8'h00);
        set_req(1, 6'h01, 32'd9, 32'd30, 8'h00);
        for (int k = 0; k < 40 && grants.size() < 4; k++) tick();
        auto_drop = 1'b1;
        check("rr_grant_count", 64'(grants.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) check("rr_order", 64'(grants[i]), 64'(i % 2));
        drain();

        // DIV from r1: divide by zero, then a regular quotient.
        set_req(1, 6'h09, 32'd100, 32'd0, 8'h00); rr_s[1] = 1'b1;
        wait_grant(1, "div0_grant");
        wait_resp(1, lat);
        check("div0_latency", 64'(lat), 64'(MD + 1));
        check("div0_result",  64'(o_res[1]), 64'hFFFF_FFFF);
        check("div0_flags",   64'(o_flo[1]), 64'h05);
        drain();
        set_req(1, 6'h09, 32'd100, 32'd7, 8'h00);
        wait_grant(1, "div_grant");
        wait_resp(1, lat);
        check("div_result", 64'(o_res[1]), 64'd14);
        check("div_flags",  64'(o_flo[1]), 64'h00);
        drain();

        // Backpressure on r0 while r1 waits.
        set_req(0, 6'h00, 32'hFFFF_FFF0, 32'h20, 8'h00); rr_s[0] = 1'b0;
        wait_grant(0, "bp_grant");
        set_req(1, 6'h02, 32'hF0F0, 32'h0FF0, 8'h00);
        wait_resp(0, lat);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp_result_held", 64'(o_res[0]), 64'h10);
            check("bp_flags_held",  64'(o_flo[0]), 64'h01);
            check("bp_r1_blocked",  64'(o_ready[1]), 64'd0);
        end
        rr_s[0] = 1'b1;
        tick();
        check("bp_accept_cycle_r1", 64'(o_ready[1]), 64'd0);
        tick();
        check("bp_next_cycle_r1", 64'(o_ready[1]), 64'd1);
        drain();

        // Reset in the middle of an r0 MUL.
        set_req(0, 6'h08, 32'd6, 32'd7, 8'h00);
        wait_grant(0, "mul_grant");
        tick(); tick();
        rst_s = 1'b0; tick(); rst_s = 1'b1;
        tick();
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_rv0",   64'(o_rv[0]), 64'd0);
        check("rst_alu_a", 64'(o_alu_a), 64'd0);
        set_req(0, 6'h00, 32'd1, 32'd1, 8'h00);
        set_req(1, 6'h00, 32'd2, 32'd2, 8'h00);
        tick();
        check("rst_r0_first", 64'(o_ready[0]), 64'd1);
        check("rst_r1_wait",  64'(o_ready[1]), 64'd0);
        drain();

        // Opcode outside the ALU's range.
        set_req(0, 6'h1F, 32'd3, 32'd4, 8'h00);
        wait_grant(0, "unk_grant");
        wait_resp(0, lat);
        check("unk_latency", 64'(lat), 64'(OT + 1));
        check("unk_result",  64'(o_res[0]), 64'd0);
        check("unk_zero",    64'(o_flo[0][1]), 64'd1);
        drain();

        // Randomized traffic from both requesters with random backpressure and rare resets.
        for (int k = 0; k < 800; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!v_s[n] && $urandom_range(0, 2) == 0) begin
                    int r;
                    logic [5:0]  op;
                    logic [31:0] b;
                    r  = $urandom_range(0, 15);
                    op = (r < 13) ? 6'(r) : 6'($urandom_range(13, 63));
                    b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
                    set_req(n, op, 32'($urandom), b, 8'($urandom));
                end
                rr_s[n] = ($urandom_range(0, 3) != 0);
            end
            rst_s = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_s = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: requester 0 is the core execute stage, requester 1 is the coprocessor/DMA helper. Each requester has a valid/ready request channel and a valid/ready response channel. Grants are round-robin. Operands are latched into registers and held stable on the ALU inputs for a per-opcode number of cycles. The result and flags are captured and held for the granted requester until it accepts them. The block sits between the requesters and the ALU instance and connects to the ALU's a/b/op/flags_in/result/flags_out pins.

Parameters:
MULDIV_CYCLES, 4, cycles the ALU inputs are held for MUL (0x08), DIV (0x09) and MOD (0x0A); legal range 1..15.
OTHER_CYCLES, 1, cycles held for every other opcode; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
rN_valid (N=0,1)  input  1  request valid for requester N.
rN_ready (N=0,1)  output  1  request accepted this cycle for requester N.
rN_op (N=0,1)  input  6  ALU opcode, 0x00–0x0C.
rN_a, rN_b (N=0,1)  input  32  operands.
rN_flags (N=0,1)  input  8  flags_in passed to the ALU.
rN_resp_valid (N=0,1)  output  1  response valid for requester N.
rN_resp_ready (N=0,1)  input  1  requester N accepts the response.
rN_result (N=0,1)  output  32  captured ALU result.
rN_flags_out (N=0,1)  output  8  captured ALU flags.
alu_a, alu_b  output  32  to ALU operand inputs.
alu_op  output  6  to ALU op.
alu_flags_in  output  8  to ALU flags_in.
alu_result  input  32  from ALU result.
alu_flags_out  input  8  from ALU flags_out.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; cycle counter 0; round-robin pointer prefers r0.
  - Operand, op and flag registers 0, so alu_* outputs are 0.
  - All rN_ready, rN_resp_valid and busy 0; response registers 0.
  - Any in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - rN_ready is combinational. It is 1 only for the requester the arbiter selects this cycle, and only while in IDLE with rst_n=1.
  - Selection: if only one rN_valid is high, grant it. If both are high, grant the requester not granted last; after reset, r0 wins first.
  - On the handshake edge: latch op/a/b/flags into the ALU input registers, record owner, update the pointer to the owner, and load the counter with (op in 0x08..0x0A ? MULDIV_CYCLES : OTHER_CYCLES). Go to EXEC.
- EXEC:
  - alu_* outputs are stable from the registers; the counter decrements each cycle.
  - On the edge where counter==1, capture alu_result/alu_flags_out into the owner's response registers and go to RESP.
  - Latency: the handshake in cycle T gives rN_resp_valid=1 in cycle T+L+1, where L is the hold count.
- RESP:
  - owner's resp_valid=1; result/flags stay held until owner resp_ready=1.
  - On that edge: resp_valid drops and the FSM returns to IDLE. The next grant occurs no earlier than the following cycle, so one operation is outstanding at most.
  - The non-owner's resp_valid stays 0 throughout.
- No requests are accepted in EXEC or RESP; rN_ready=0 there.
- Opcodes above 0x0C are forwarded unchanged using OTHER_CYCLES; the response carries whatever the ALU returns (0 result).
- The pointer updates only on a grant. A lone requester is granted repeatedly.
- rN_resp_ready is ignored when the matching resp_valid is 0.
- A request's valid and payload must be held by the requester until ready; the block does not check this.

Test Plan:
- r0 only, op=0x00, a=5, b=7, flags=0x00: r0_ready in cycle T, r0_resp_valid in cycle T+2, result=12, flags_out=0x00, busy high T+1..T+2.
- Both requesters valid continuously, op=0x01: grants go r0, r1, r0, r1 after reset; each response appears only on its own channel.
- r1 op=0x09, a=100, b=0 with MULDIV_CYCLES=4: alu_* stable for 4 cycles, r1_resp_valid in cycle T+5, result=0xFFFFFFFF, flags_out=0x05; r1 op=0x09, a=100, b=7 yields 14, flags_out=0x00.
- Backpressure: r0 ADD response with r0_resp_ready=0 for 6 cycles: result and flags held constant, r1_valid=1 not granted until the cycle after r0_resp_ready=1.
- rst_n=0 for one cycle during EXEC of r0 MUL: the next cycle has busy=0, no resp_valid, alu_*=0, and the next simultaneous request is granted to r0.
- Unknown op 0x1F, a=3, b=4: latency OTHER_CYCLES+1, result=0, flags_out zero bit (bit1) set.
